// File: rtl/ofs_pcie_rd_req_splitter.sv
// Splits DW-aligned host reads into tagged PCIe MRd requests that never
// cross a MAX_RD_REQ_BYTES-aligned boundary.
module ofs_pcie_rd_req_splitter #(
  parameter int MAX_RD_REQ_BYTES = 512,
  parameter int NUM_TAGS = 256,
  parameter int ADDR_W = 64,
  parameter int LEN_W = 16,
  localparam int TAG_W = $clog2(NUM_TAGS),
  localparam int LDW_W = $clog2(MAX_RD_REQ_BYTES/4)+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [LEN_W-1:0]  in_len_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [LDW_W-1:0]  out_len_dw,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_last,
  input  logic              tag_free_valid,
  input  logic [TAG_W-1:0]  tag_free,
  output logic [TAG_W:0]    tags_in_use,
  output logic              err_tag_release
);

  localparam int OFF_W = $clog2(MAX_RD_REQ_BYTES);
  localparam int CNT_W = TAG_W + 1;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   src_addr;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    src_rem;
  logic [LEN_W-1:0]    room;
  logic [LEN_W-1:0]    chunk;
  logic [OFF_W-1:0]    off;
  logic                last_c;
  logic [NUM_TAGS-1:0] busy;
  logic [NUM_TAGS-1:0] set_v;
  logic [NUM_TAGS-1:0] clr_v;
  logic [TAG_W-1:0]    free_idx;
  logic                any_free;
  logic                accept;
  logic                start;
  logic                load;
  logic                fire;
  logic                rel_ok;

  assign accept = in_valid & in_ready;
  assign start  = accept & (in_len_bytes != '0);
  assign fire   = out_valid & out_ready;
  assign rel_ok = tag_free_valid & busy[tag_free];

  // On acceptance the chunk is cut straight from the inputs so the
  // first request can be presented in the very next cycle.
  assign src_addr = (state == IDLE) ? in_addr : cur_addr;
  assign src_rem  = (state == IDLE) ? in_len_bytes : remaining;
  assign off      = src_addr[OFF_W-1:0];
  assign room     = LEN_W'(MAX_RD_REQ_BYTES) - LEN_W'(off);
  assign chunk    = (src_rem < room) ? src_rem : room;
  assign last_c   = (src_rem <= room);

  assign any_free = ~&busy;
  assign load = any_free &
                (start | (state == SPLIT & !out_valid));

  always_comb begin
    free_idx = '0;
    for (int i = NUM_TAGS-1; i >= 0; i--) begin
      if (!busy[i]) free_idx = TAG_W'(i);
    end
  end

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (fire)   set_v[out_tag]  = 1'b1;
    if (rel_ok) clr_v[tag_free] = 1'b1;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (start) state_d = SPLIT;
      SPLIT: if (fire & out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready        <= 1'b0;
      cur_addr        <= '0;
      remaining       <= '0;
      out_valid       <= 1'b0;
      out_addr        <= '0;
      out_len_dw      <= '0;
      out_tag         <= '0;
      out_last        <= 1'b0;
      busy            <= '0;
      tags_in_use     <= '0;
      err_tag_release <= 1'b0;
    end else begin
      in_ready <= (state_d == IDLE);
      if (start) begin
        cur_addr  <= in_addr;
        remaining <= in_len_bytes;
      end else if (fire) begin
        cur_addr  <= out_addr + ADDR_W'({out_len_dw, 2'b00});
        remaining <= remaining - LEN_W'({out_len_dw, 2'b00});
      end
      // Fields are frozen once presented; only a handshake releases them.
      if (load) begin
        out_valid  <= 1'b1;
        out_addr   <= src_addr;
        out_len_dw <= LDW_W'(chunk >> 2);
        out_tag    <= free_idx;
        out_last   <= last_c;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      busy        <= (busy & ~clr_v) | set_v;
      tags_in_use <= tags_in_use + CNT_W'(fire) - CNT_W'(rel_ok);
      if (tag_free_valid & !busy[tag_free]) err_tag_release <= 1'b1;
    end
  end

  a_aligned: assert property (
    @(posedge clk) disable iff (!rst_n)
    accept |-> (in_addr[1:0] == 2'b00 && in_len_bytes[1:0] == 2'b00)
  );

endmodule

// File: tb/tb_ofs_pcie_rd_req_splitter.sv
// Directed bench for the read request splitter (512 B max, 8 tags).
module tb_ofs_pcie_rd_req_splitter;

  localparam int AW = 64;
  localparam int LW = 16;
  localparam int NT = 8;
  localparam int TW = 3;
  localparam int DWW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [LW-1:0] in_len_bytes;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DWW-1:0] out_len_dw;
  logic [TW-1:0] out_tag;
  logic          out_last;
  logic          tag_free_valid;
  logic [TW-1:0] tag_free;
  logic [TW:0]   tags_in_use;
  logic          err_tag_release;

  int n_cmp = 0;
  int n_err = 0;

  ofs_pcie_rd_req_splitter #(
    .MAX_RD_REQ_BYTES(512),
    .NUM_TAGS(NT),
    .ADDR_W(AW),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_len_bytes(in_len_bytes),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_len_dw(out_len_dw),
    .out_tag(out_tag),
    .out_last(out_last),
    .tag_free_valid(tag_free_valid),
    .tag_free(tag_free),
    .tags_in_use(tags_in_use),
    .err_tag_release(err_tag_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [15:0] l);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_addr = a;
    in_len_bytes = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take(input logic [63:0] a, input int dw,
                      input int tg, input logic last);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_addr", out_addr, a);
    chk("out_len_dw", 64'(out_len_dw), 64'(dw));
    chk("out_tag", 64'(out_tag), 64'(tg));
    chk("out_last", 64'(out_last), 64'(last));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'(last));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_addr = '0;
    in_len_bytes = '0;
    out_ready = 1'b0;
    tag_free_valid = 1'b0;
    tag_free = '0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", out_addr, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_tiu", 64'(tags_in_use), 64'd0);
    chk("rst_err", 64'(err_tag_release), 64'd0);
    rst_n = 1'b1;

    send(64'h1000, 16'd2048);
    take(64'h1000, 128, 0, 1'b0);
    take(64'h1200, 128, 1, 1'b0);
    take(64'h1400, 128, 2, 1'b0);
    take(64'h1600, 128, 3, 1'b1);
    chk("tiu_aligned", 64'(tags_in_use), 64'd4);

    send(64'h11F0, 16'h40);
    take(64'h11F0, 4, 4, 1'b0);
    take(64'h1200, 12, 5, 1'b1);
    chk("tiu_unaligned", 64'(tags_in_use), 64'd6);

    send(64'h2000, 16'd0);
    chk("zero_valid", 64'(out_valid), 64'd0);
    chk("zero_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("zero_valid2", 64'(out_valid), 64'd0);
    chk("zero_tiu", 64'(tags_in_use), 64'd6);

    // Tag 1 comes back while tag 6 is stalled on the bus.
    send(64'h3000, 16'd512);
    for (int i = 0; i < 10; i++) begin
      tag_free_valid = (i == 2);
      tag_free = 3'd1;
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_tag", 64'(out_tag), 64'd6);
      chk("bp_addr", out_addr, 64'h3000);
      chk("bp_len", 64'(out_len_dw), 64'd128);
    end
    tag_free_valid = 1'b0;
    chk("bp_tiu_freed", 64'(tags_in_use), 64'd5);
    take(64'h3000, 128, 6, 1'b1);
    chk("bp_tiu", 64'(tags_in_use), 64'd6);

    tag_free_valid = 1'b1;
    tag_free = 3'd7;
    tick();
    tag_free_valid = 1'b0;
    chk("err_set", 64'(err_tag_release), 64'd1);
    chk("err_tiu", 64'(tags_in_use), 64'd6);

    send(64'h8000, 16'd2048);
    take(64'h8000, 128, 1, 1'b0);
    take(64'h8200, 128, 7, 1'b0);
    chk("full_valid", 64'(out_valid), 64'd0);
    chk("full_tiu", 64'(tags_in_use), 64'd8);
    tick();
    chk("full_valid2", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_tiu", 64'(tags_in_use), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_err", 64'(err_tag_release), 64'd0);
    tick();
    rst_n = 1'b1;

    send(64'h0, 16'd5120);
    for (int i = 0; i < 8; i++) begin
      take(64'(i) * 64'h200, 128, i, 1'b0);
    end
    chk("exh_valid", 64'(out_valid), 64'd0);
    chk("exh_tiu", 64'(tags_in_use), 64'd8);
    tick();
    chk("exh_valid2", 64'(out_valid), 64'd0);
    tag_free_valid = 1'b1;
    tag_free = 3'd2;
    tick();
    tag_free_valid = 1'b0;
    chk("exh_same_cycle", 64'(out_valid), 64'd0);
    chk("exh_tiu_freed", 64'(tags_in_use), 64'd7);
    tick();
    take(64'h1000, 128, 2, 1'b0);
    tag_free_valid = 1'b1;
    tag_free = 3'd0;
    tick();
    tag_free_valid = 1'b0;
    chk("exh_same_cycle2", 64'(out_valid), 64'd0);
    tick();
    take(64'h1200, 128, 0, 1'b1);
    chk("exh_tiu_end", 64'(tags_in_use), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
